// File: rtl/emblem_seq.sv
// Frame-synchronous emblem overlay sequencer: wipe-in, hold, blink, wipe-out; state moves only on frame_start.
// Outputs register one clk after a tick; emblem_gate is combinational in y. EMBLEM_SEQ_AUTOLOOP_EN adds timed auto-restart.
module emblem_seq #(
    parameter int EMBLEM_Y0    = 144,
    parameter int EMBLEM_H     = 160,
    parameter int WIPE_STEP    = 4,
    parameter int HOLD_FRAMES  = 120,
    parameter int BLINK_PERIOD = 8,
    parameter int BLINK_COUNT  = 3,
    parameter int LOOP_GAP     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       start,
    input  logic       stop,
    input  logic [9:0] y,
    output logic       overlay_en,
    output logic [7:0] reveal,
    output logic       emblem_gate,
    output logic       highlight,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WIPE_IN  = 3'd1;
    localparam logic [2:0] S_HOLD     = 3'd2;
    localparam logic [2:0] S_BLINK    = 3'd3;
    localparam logic [2:0] S_WIPE_OUT = 3'd4;

    localparam logic [8:0] H9         = 9'(EMBLEM_H);
    localparam logic [8:0] STEP9      = 9'(WIPE_STEP);
    localparam logic [8:0] HOLD_LAST  = 9'(HOLD_FRAMES - 1);
    localparam logic [8:0] BLINK_LAST = 9'(BLINK_PERIOD - 1);
    localparam logic [3:0] TOG_END    = 4'(2 * BLINK_COUNT - 1);
    localparam logic [9:0] Y0         = 10'(EMBLEM_Y0);

    logic [2:0] state;
    logic [8:0] cnt;
    logic [3:0] tog;
    logic       start_pend;
    logic       stop_pend;
    logic       start_req;
    logic       stop_req;
    logic [8:0] reveal9;
    logic [8:0] reveal_up;
    logic [8:0] reveal_dn;
    logic [3:0] tog_next;
    logic       auto_go;

    // A request coincident with the tick counts at that tick.
    assign start_req = start_pend | start;
    assign stop_req  = stop_pend | stop;
    assign reveal9   = {1'b0, reveal};
    assign reveal_up = reveal9 + STEP9;
    assign reveal_dn = reveal9 - STEP9;
    assign tog_next  = tog + 4'd1;

    assign emblem_gate = overlay_en && (y >= Y0) && ((y - Y0) < {2'b00, reveal});

`ifdef EMBLEM_SEQ_AUTOLOOP_EN
    localparam logic [8:0] GAP_LAST = 9'(LOOP_GAP - 1);

    logic       loop_arm;
    logic       aborted;
    logic [8:0] gap;

    assign auto_go = loop_arm && (gap == GAP_LAST);

    // Only a natural completion arms the restart; any stop along the way disqualifies it.
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_arm <= 1'b0;
            aborted  <= 1'b0;
            gap      <= 9'd0;
        end else if (frame_start) begin
            case (state)
                S_IDLE: begin
                    if (stop_req) begin
                        loop_arm <= 1'b0;
                    end else if (start_req || auto_go) begin
                        loop_arm <= 1'b0;
                        aborted  <= 1'b0;
                        gap      <= 9'd0;
                    end else if (loop_arm) begin
                        gap <= gap + 9'd1;
                    end
                end
                S_WIPE_IN, S_HOLD, S_BLINK: begin
                    if (stop_req) aborted <= 1'b1;
                end
                S_WIPE_OUT: begin
                    if (reveal9 <= STEP9) begin
                        loop_arm <= !aborted;
                        gap      <= 9'd0;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign auto_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 9'd0;
            tog        <= 4'd0;
            start_pend <= 1'b0;
            stop_pend  <= 1'b0;
            overlay_en <= 1'b0;
            reveal     <= 8'd0;
            highlight  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!frame_start) begin
                start_pend <= start_pend | start;
                stop_pend  <= stop_pend | stop;
            end else begin
                start_pend <= 1'b0;
                stop_pend  <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (!stop_req && (start_req || auto_go)) begin
                            state      <= S_WIPE_IN;
                            busy       <= 1'b1;
                            overlay_en <= 1'b1;
                            reveal     <= 8'd0;
                            highlight  <= 1'b0;
                        end
                    end
                    S_WIPE_IN: begin
                        if (stop_req) begin
                            state <= S_WIPE_OUT;
                        end else if (reveal_up >= H9) begin
                            reveal <= H9[7:0];
                            state  <= S_HOLD;
                            cnt    <= 9'd0;
                        end else begin
                            reveal <= reveal_up[7:0];
                        end
                    end
                    S_HOLD: begin
                        if (stop_req) begin
                            state <= S_WIPE_OUT;
                        end else if (cnt == HOLD_LAST) begin
                            state     <= S_BLINK;
                            cnt       <= 9'd0;
                            tog       <= 4'd0;
                            highlight <= 1'b1;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                    S_BLINK: begin
                        if (stop_req) begin
                            state     <= S_WIPE_OUT;
                            highlight <= 1'b0;
                        end else if (cnt == BLINK_LAST) begin
                            cnt       <= 9'd0;
                            highlight <= ~highlight;
                            tog       <= tog_next;
                            // Odd toggle count leaves highlight off on exit.
                            if (tog_next == TOG_END) state <= S_WIPE_OUT;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                    S_WIPE_OUT: begin
                        if (reveal9 <= STEP9) begin
                            reveal     <= 8'd0;
                            overlay_en <= 1'b0;
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            reveal <= reveal_dn[7:0];
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_emblem_seq.sv
// Directed bench for emblem_seq: default show timeline, request timing, abort, reset mid-show, odd wipe step.
module tb_emblem_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [9:0] y1 = 10'd0;
    logic [9:0] y7 = 10'd0;

    logic       overlay_en1, emblem_gate1, highlight1, busy1, done1;
    logic [7:0] reveal1;
    logic       overlay_en7, emblem_gate7, highlight7, busy7, done7;
    logic [7:0] reveal7;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    emblem_seq dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .start(start), .stop(stop), .y(y1),
        .overlay_en(overlay_en1), .reveal(reveal1), .emblem_gate(emblem_gate1),
        .highlight(highlight1), .busy(busy1), .done(done1)
    );

    emblem_seq #(.WIPE_STEP(7)) dut7 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .start(start), .stop(stop), .y(y7),
        .overlay_en(overlay_en7), .reveal(reveal7), .emblem_gate(emblem_gate7),
        .highlight(highlight7), .busy(busy7), .done(done7)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic s, input logic p);
        @(negedge clk);
        frame_start = 1'b1;
        start = s;
        stop = p;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic cycle(input logic s, input logic p);
        @(negedge clk);
        start = s;
        stop = p;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
    endtask

    function automatic int exp_reveal(input int k);
        if (k <= 40) return (4 * k > 160) ? 160 : 4 * k;
        if (k <= 200) return 160;
        return (160 - 4 * (k - 200) < 0) ? 0 : 160 - 4 * (k - 200);
    endfunction

    function automatic int exp_hl(input int k);
        if (k >= 160 && k < 200) return (((k - 160) / 8) % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    task automatic run_full(input logic coincident);
        if (coincident) begin
            tick(1'b1, 1'b0);
        end else begin
            cycle(1'b1, 1'b0);
            check("start_between_ticks_waits", busy1, 0);
            tick(1'b0, 1'b0);
        end
        check("t0_busy", busy1, 1);
        check("t0_overlay_en", overlay_en1, 1);
        check("t0_reveal", reveal1, 0);
        for (int k = 1; k <= 240; k++) begin
            tick((k == 100) ? 1'b1 : 1'b0, 1'b0);
            check($sformatf("reveal_t%0d", k), reveal1, exp_reveal(k));
            check($sformatf("highlight_t%0d", k), highlight1, exp_hl(k));
            check($sformatf("busy_t%0d", k), busy1, (k < 240) ? 1 : 0);
            check($sformatf("done_t%0d", k), done1, (k == 240) ? 1 : 0);
            if (k == 20) begin
                y1 = 10'd223;
                #1 check("gate_last_row", emblem_gate1, 1);
                y1 = 10'd224;
                #1 check("gate_past_reveal", emblem_gate1, 0);
                y1 = 10'd143;
                #1 check("gate_above_box", emblem_gate1, 0);
            end
        end
        check("overlay_off_end", overlay_en1, 0);
        cycle(1'b0, 1'b0);
        check("done_single_clk", done1, 0);
        check("busy_after", busy1, 0);
    endtask

    initial begin
        // Reset dominates start and frame_start.
        @(negedge clk);
        rst = 1'b1;
        frame_start = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        start = 1'b0;
        cycle(1'b0, 1'b0);
        rst = 1'b0;
        check("rst_overlay_en", overlay_en1, 0);
        check("rst_reveal", reveal1, 0);
        check("rst_highlight", highlight1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_gate", emblem_gate1, 0);

        // Full timeline, start between ticks; start at T100 is ignored.
        run_full(1'b0);

        // Stop while idle is ignored.
        tick(1'b0, 1'b1);
        check("idle_stop_busy", busy1, 0);
        check("idle_stop_done", done1, 0);

        // Coincident start, then stop after T20 consumed at T21.
        tick(1'b1, 1'b0);
        check("coinc_start_busy", busy1, 1);
        for (int k = 1; k <= 20; k++) tick(1'b0, 1'b0);
        check("abort_pre_reveal", reveal1, 80);
        cycle(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("abort_hold_reveal", reveal1, 80);
        check("abort_busy", busy1, 1);
        for (int j = 1; j <= 20; j++) begin
            tick(1'b0, (j == 5) ? 1'b1 : 1'b0);
            check($sformatf("abort_reveal_j%0d", j), reveal1, (80 - 4 * j < 0) ? 0 : 80 - 4 * j);
            check($sformatf("abort_hl_j%0d", j), highlight1, 0);
            check($sformatf("abort_done_j%0d", j), done1, (j == 20) ? 1 : 0);
            check($sformatf("abort_busy_j%0d", j), busy1, (j < 20) ? 1 : 0);
        end

        // Start and stop together while idle: stop wins.
        cycle(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        check("both_pend_busy", busy1, 0);
        check("both_pend_done", done1, 0);
        tick(1'b1, 1'b1);
        check("both_live_busy", busy1, 0);
        check("both_live_overlay", overlay_en1, 0);

        // Reset in the middle of BLINK.
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 165; k++) tick(1'b0, 1'b0);
        check("blink_hl_before_rst", highlight1, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_overlay_en", overlay_en1, 0);
        check("midrst_reveal", reveal1, 0);
        check("midrst_highlight", highlight1, 0);
        check("midrst_busy", busy1, 0);
        check("midrst_done", done1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full show after reset with coincident start.
        run_full(1'b1);

`ifdef EMBLEM_SEQ_AUTOLOOP_EN
        for (int j = 1; j <= 59; j++) tick(1'b0, 1'b0);
        check("autoloop_gap_idle", busy1, 0);
        tick(1'b0, 1'b0);
        check("autoloop_restart_busy", busy1, 1);
        check("autoloop_restart_reveal", reveal1, 0);
`else
        for (int j = 1; j <= 60; j++) tick(1'b0, 1'b0);
        check("no_autoloop_idle", busy1, 0);
`endif

        // WIPE_STEP=7 instance: saturating wipe-in and odd wipe-out.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 1'b0);
        check("s7_t0_reveal", reveal7, 0);
        for (int k = 1; k <= 206; k++) begin
            int e;
            tick(1'b0, 1'b0);
            if (k <= 23) e = (7 * k > 160) ? 160 : 7 * k;
            else if (k <= 183) e = 160;
            else e = (160 - 7 * (k - 183) < 0) ? 0 : 160 - 7 * (k - 183);
            check($sformatf("s7_reveal_t%0d", k), reveal7, e);
            check($sformatf("s7_done_t%0d", k), done7, (k == 206) ? 1 : 0);
            if (k == 23) begin
                y7 = 10'd304;
                #1 check("s7_gate_at_reveal", emblem_gate7, 0);
                y7 = 10'd303;
                #1 check("s7_gate_last_row", emblem_gate7, 1);
            end
        end
        check("s7_busy_end", busy7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
